// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen
// Brief   : Parametrised raster timing generator with sync, blanking, DE,
//           line/frame pulses and a fetch-lead strobe for pipeline prefetch.
// Revision: 1.0
// ============================================================================
module vga_timing_gen #(
    parameter int HACT   = 640,
    parameter int HFP    = 16,
    parameter int HSW    = 96,
    parameter int HBP    = 48,
    parameter int VACT   = 480,
    parameter int VFP    = 10,
    parameter int VSW    = 2,
    parameter int VBP    = 33,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int LEAD   = 2,
    parameter int CW     = 11
) (
    input  logic          I_CLK,
    input  logic          I_RST,
    input  logic          I_CE,
    input  logic          I_RESYNC,
    output logic [CW-1:0] O_H_CNT,
    output logic [CW-1:0] O_V_CNT,
    output logic          O_HS,
    output logic          O_VS,
    output logic          O_DE,
    output logic          O_HBLANK,
    output logic          O_VBLANK,
    output logic          O_FETCH,
    output logic          O_SOL,
    output logic          O_SOF
);

    localparam int HTOTAL = HACT + HFP + HSW + HBP;
    localparam int VTOTAL = VACT + VFP + VSW + VBP;
    localparam int CW1    = CW + 1;

    localparam logic [CW-1:0] C_H_LAST = CW'(HTOTAL - 1);
    localparam logic [CW-1:0] C_V_LAST = CW'(VTOTAL - 1);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    // Decode thresholds carry one extra bit so a total of exactly 2^CW cannot alias to zero.
    localparam logic [CW:0] C_HACT   = CW1'(HACT);
    localparam logic [CW:0] C_VACT   = CW1'(VACT);
    localparam logic [CW:0] C_HS_BEG = CW1'(HACT + HFP);
    localparam logic [CW:0] C_HS_END = CW1'(HACT + HFP + HSW);
    localparam logic [CW:0] C_VS_BEG = CW1'(VACT + VFP);
    localparam logic [CW:0] C_VS_END = CW1'(VACT + VFP + VSW);
    localparam logic [CW:0] C_HTOT   = CW1'(HTOTAL);
    localparam logic [CW:0] C_LEAD   = CW1'(LEAD);

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          hs_q, vs_q, de_q, hblank_q, vblank_q, fetch_q, sol_q, sof_q;
    logic          hs_d, vs_d, de_d, hblank_d, vblank_d, fetch_d, sol_d, sof_d;

    logic [CW:0]   hx, vx, t_lead, t_wrap, vnx;
    logic [CW-1:0] v_next;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (I_CE) begin
            if (I_RESYNC) begin
                h_d = '0;
                v_d = '0;
            end else if (h_q == C_H_LAST) begin
                h_d = '0;
                v_d = (v_q == C_V_LAST) ? '0 : v_q + C_ONE;
            end else begin
                h_d = h_q + C_ONE;
            end
        end
    end

    // Outputs decode the next counter value so they line up with O_H_CNT/O_V_CNT.
    always_comb begin
        hx       = {1'b0, h_d};
        vx       = {1'b0, v_d};
        de_d     = (hx < C_HACT) && (vx < C_VACT);
        hblank_d = !(hx < C_HACT);
        vblank_d = !(vx < C_VACT);
        hs_d     = ((hx >= C_HS_BEG) && (hx < C_HS_END)) ? HS_POL : ~HS_POL;
        vs_d     = ((vx >= C_VS_BEG) && (vx < C_VS_END)) ? VS_POL : ~VS_POL;

        // A lead that runs past the end of the line looks at the following line.
        v_next   = (v_d == C_V_LAST) ? '0 : v_d + C_ONE;
        vnx      = {1'b0, v_next};
        t_lead   = hx + C_LEAD;
        t_wrap   = t_lead - C_HTOT;
        if (t_lead < C_HTOT) begin
            fetch_d = (t_lead < C_HACT) && (vx < C_VACT);
        end else begin
            fetch_d = (t_wrap < C_HACT) && (vnx < C_VACT);
        end

        sol_d    = I_CE && (h_d == '0);
        sof_d    = sol_d && (v_d == '0);
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            h_q      <= C_H_LAST;
            v_q      <= C_V_LAST;
            hs_q     <= ~HS_POL;
            vs_q     <= ~VS_POL;
            de_q     <= 1'b0;
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            fetch_q  <= (LEAD > 0);
            sol_q    <= 1'b0;
            sof_q    <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            de_q     <= de_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            fetch_q  <= fetch_d;
            sol_q    <= sol_d;
            sof_q    <= sof_d;
        end
    end

    assign O_H_CNT  = h_q;
    assign O_V_CNT  = v_q;
    assign O_HS     = hs_q;
    assign O_VS     = vs_q;
    assign O_DE     = de_q;
    assign O_HBLANK = hblank_q;
    assign O_VBLANK = vblank_q;
    assign O_FETCH  = fetch_q;
    assign O_SOL    = sol_q;
    assign O_SOF    = sof_q;

endmodule
`default_nettype wire
